move_input_ctrl: RTL
====================

# move_input_ctrl

Player-move initiator for the minesweeper board FSM. It debounces five raw pushbuttons, keeps a cursor position and a move type, and drives the game's `inx`/`iny`/`in_type`/`conf_mov` inputs. It sits between the board pins and the minesweeper top. The game waits in its move-wait state while `conf_mov` is 1, commits the move when `conf_mov` goes to 0, and then re-renders the board.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: number of consecutive clock edges a synchronized key must differ from its debounced value before the debounced value changes (minimum 2).
- `CONF_PULSE`, default 4: number of cycles `conf_mov` is held at 0 for each committed move.
- `HOLDOFF_CYCLES`, default 8192: cycles `conf_mov` stays at 1 after a pulse before the next move can start. Must exceed the game's render time.
- `BOARD_W`, default 9: cursor x range is 0..BOARD_W-1.
- `BOARD_H`, default 9: cursor y range is 0..BOARD_H-1.
- `clk` input 1: clock clk.
- `rst` input 1: reset rst, asynchronous, active-low.
- `key_up`, `key_down`, `key_left`, `key_right` input 1 each: raw direction keys, active-low, asynchronous to `clk`.
- `key_mode` input 1: raw key that toggles the move type, active-low.
- `key_confirm` input 1: raw key that commits a move, active-low.
- `inx` output 4: cursor column. Reset value 0.
- `iny` output 4: cursor row. Reset value 0.
- `in_type` output 4: board code to write. Either 4'd10 (flag) or 4'd0 (clear). Reset value 4'd10.
- `conf_mov` output 1: move strobe, active-low. Reset value 1.
- `busy` output 1: high whenever the FSM is not in IDLE. Reset value 0.

## Operation
Key conditioning, identical for each of the six keys:
- 2-flop synchronizer.
- Saturating counter that resets whenever the synchronized value equals the debounced value.
- Debounced value resets to 1 (released).
- A registered one-cycle press event is generated on each debounced 1→0 transition. Releases produce no event.

Cursor, updated only in IDLE:
- up: `iny` − 1. down: `iny` + 1. left: `inx` − 1. right: `inx` + 1.
- Boundary behaviour at 0 and at BOARD_W-1 / BOARD_H-1 is set by the configuration macro below.
- Opposing presses in the same cycle (up+down, or left+right) cancel on that axis. The two axes update independently.
- mode press toggles `in_type` between 10 and 0.

FSM states:
- **IDLE**: `conf_mov`=1. A confirm event moves to ASSERT and latches the current cursor and type. Any direction or mode event in the same cycle as confirm is discarded.
- **ASSERT**: `conf_mov`=0 for exactly CONF_PULSE cycles, then go to HOLDOFF.
- **HOLDOFF**: `conf_mov`=1. Count HOLDOFF_CYCLES cycles, then go to WAIT_REL.
- **WAIT_REL**: wait until the debounced confirm key is 1, then go to IDLE.

Rules outside IDLE:
- `inx`, `iny` and `in_type` are frozen from ASSERT entry until the return to IDLE. Direction, mode and confirm events outside IDLE are dropped, not queued.
- Holding confirm down produces exactly one move.
- Reset asserted at any point forces `conf_mov` to 1, all outputs to their reset values, and the FSM to IDLE, asynchronously.

## Timing
- Raw key falls before edge 1 and stays low:
  - synchronized low at edge 2;
  - debounced low at edge 2+DEBOUNCE_CYCLES;
  - press event high during the cycle after edge 3+DEBOUNCE_CYCLES;
  - cursor/type update, or ASSERT entry, at edge 4+DEBOUNCE_CYCLES.
- A raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no event.
- `conf_mov` falls at ASSERT entry and rises exactly CONF_PULSE edges later.
- `inx`, `iny` and `in_type` are stable from one cycle before `conf_mov` falls through the end of HOLDOFF.
- Earliest next `conf_mov` fall: CONF_PULSE + HOLDOFF_CYCLES + 1 + debounce latency after the previous fall.

## Configuration
- `CURSOR_WRAP_EN` defined: the cursor wraps around.
  - right at BOARD_W-1 → 0; left at 0 → BOARD_W-1.
  - down at BOARD_H-1 → 0; up at 0 → BOARD_H-1.
- Not defined: the cursor saturates. Moves past 0 or past BOARD_W-1 / BOARD_H-1 leave it unchanged.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, CONF_PULSE=4, HOLDOFF_CYCLES=16, 9×9 board.
- **Reset**: deassert rst → `conf_mov`=1, `inx`=0, `iny`=0, `in_type`=10, `busy`=0.
- **Single move**: press right 3 times and down 2 times, each held 10 cycles, then confirm → `inx`=3, `iny`=2. `conf_mov` falls 8 edges after raw confirm falls and stays 0 for exactly 4 cycles.
- **Glitch and hold**:
  - a 3-cycle raw low on left → `inx` unchanged;
  - confirm held low for 200 cycles → exactly one `conf_mov` pulse.
- **Boundary**: from `inx`=0, press left.
  - Without the macro: stays 0.
  - With `CURSOR_WRAP_EN`: becomes 8.
  - Also press right at 8 → 8 (saturate) or 0 (wrap).
- **Freeze**:
  - press mode → `in_type`=0;
  - confirm, then press right during HOLDOFF → `inx` unchanged after return to IDLE;
  - left+right in the same cycle in IDLE → `inx` unchanged.
- **Reset mid-pulse**: assert rst during ASSERT → `conf_mov`=1 immediately (before the next clock edge), and `busy`=0.

Source files
------------

// File: rtl/move_input_ctrl.sv
// move_input_ctrl: debounced keys drive cursor, move type and the conf_mov strobe.
// Optional macro CURSOR_WRAP_EN makes the cursor wrap at the board edges.
module move_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CONF_PULSE      = 4,
   parameter int HOLDOFF_CYCLES  = 8192,
   parameter int BOARD_W         = 9,
   parameter int BOARD_H         = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_mode,
   input  logic       key_confirm,
   output logic [3:0] inx,
   output logic [3:0] iny,
   output logic [3:0] in_type,
   output logic       conf_mov,
   output logic       busy
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int TC = (CONF_PULSE > HOLDOFF_CYCLES) ?
                       CONF_PULSE : HOLDOFF_CYCLES;
   localparam int TW = $clog2(TC + 1);
   localparam logic [3:0] XMAX = 4'(BOARD_W - 1);
   localparam logic [3:0] YMAX = 4'(BOARD_H - 1);

   localparam int K_UP    = 0;
   localparam int K_DOWN  = 1;
   localparam int K_LEFT  = 2;
   localparam int K_RIGHT = 3;
   localparam int K_MODE  = 4;
   localparam int K_CONF  = 5;

   typedef enum logic [1:0] {
      IDLE,
      ASSERT,
      HOLDOFF,
      WAIT_REL
   } state_t;

   logic [5:0]    raw;
   logic [5:0]    s1_q;
   logic [5:0]    s2_q;
   logic [5:0]    deb_q;
   logic [5:0]    debp_q;
   logic [5:0]    ev_q;
   logic [DW-1:0] cnt_q [6];

   state_t        st_q;
   logic [TW-1:0] tcnt_q;
   logic [3:0]    x_q;
   logic [3:0]    y_q;
   logic          flag_q;
   logic          conf_q;
   logic          busy_q;

   assign raw = {key_confirm, key_mode, key_right,
                 key_left, key_down, key_up};

   // Counter restarts whenever the synchronized key agrees with its debounced value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q   <= '1;
         s2_q   <= '1;
         deb_q  <= '1;
         debp_q <= '1;
         ev_q   <= '0;
         for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
      end else begin
         s1_q   <= raw;
         s2_q   <= s1_q;
         debp_q <= deb_q;
         ev_q   <= debp_q & ~deb_q;
         for (int i = 0; i < 6; i++) begin
            if (s2_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               cnt_q[i] <= '0;
               deb_q[i] <= s2_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   function automatic logic [3:0] step(input logic [3:0] v,
                                       input logic       inc,
                                       input logic [3:0] vmax);
      logic [3:0] r;
      if (inc) begin
`ifdef CURSOR_WRAP_EN
         r = (v >= vmax) ? 4'd0 : v + 4'd1;
`else
         r = (v >= vmax) ? vmax : v + 4'd1;
`endif
      end else begin
`ifdef CURSOR_WRAP_EN
         r = (v == 4'd0) ? vmax : v - 4'd1;
`else
         r = (v == 4'd0) ? 4'd0 : v - 4'd1;
`endif
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q   <= IDLE;
         tcnt_q <= '0;
         x_q    <= '0;
         y_q    <= '0;
         flag_q <= 1'b1;
         conf_q <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         unique case (st_q)
            IDLE: begin
               if (ev_q[K_CONF]) begin
                  st_q   <= ASSERT;
                  tcnt_q <= '0;
                  conf_q <= 1'b0;
                  busy_q <= 1'b1;
               end else begin
                  if (ev_q[K_RIGHT] ^ ev_q[K_LEFT])
                     x_q <= step(x_q, ev_q[K_RIGHT], XMAX);
                  if (ev_q[K_DOWN] ^ ev_q[K_UP])
                     y_q <= step(y_q, ev_q[K_DOWN], YMAX);
                  if (ev_q[K_MODE])
                     flag_q <= ~flag_q;
               end
            end
            ASSERT: begin
               if (tcnt_q == TW'(CONF_PULSE - 1)) begin
                  st_q   <= HOLDOFF;
                  tcnt_q <= '0;
                  conf_q <= 1'b1;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
            end
            HOLDOFF: begin
               if (tcnt_q == TW'(HOLDOFF_CYCLES - 1)) begin
                  st_q   <= WAIT_REL;
                  tcnt_q <= '0;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
            end
            WAIT_REL: begin
               if (deb_q[K_CONF]) begin
                  st_q   <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               st_q   <= IDLE;
               conf_q <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign inx      = x_q;
   assign iny      = y_q;
   assign in_type  = flag_q ? 4'd10 : 4'd0;
   assign conf_mov = conf_q;
   assign busy     = busy_q;

endmodule
